// File: rtl/compute_c_sdiv_25s_16s_16_seq.sv
// ---------------------------------------------------------------------------
// compute_c_sdiv_25s_16s_16_seq
// Sequential signed divider using radix-2 restoring division, one quotient
// bit per enabled clock. The quotient truncates toward zero. The remainder
// takes the sign of the dividend.
//
// Latency: done rises din0_WIDTH+2 enabled edges after the edge that
// captured start, and stays high for one enabled cycle.
//
// Optional feature: define COMPUTE_C_SDIV_REM_EN to add the rem output port
// and its register.
//
// Ports:
//   ap_clk  in   clock; all state changes on its rising edge
//   ap_rst  in   synchronous active-high reset (wins over ce)
//   ce      in   clock enable; 0 freezes every register
//   start   in   begin a division (honoured only while idle)
//   din0    in   signed dividend, din0_WIDTH bits
//   din1    in   signed divisor, din1_WIDTH bits
//   done    out  result-valid pulse
//   dout    out  signed quotient (low dout_WIDTH bits of the exact quotient)
//   rem     out  signed remainder (only with COMPUTE_C_SDIV_REM_EN)
// ---------------------------------------------------------------------------
module compute_c_sdiv_25s_16s_16_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 25,
  parameter int din1_WIDTH = 16,
  parameter int dout_WIDTH = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout
`ifdef COMPUTE_C_SDIV_REM_EN
  ,
  output logic [din1_WIDTH-1:0] rem
`endif
);

  localparam int CW = $clog2(din0_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_t;

  // Two's-complement negate when s is set (dividend-width operands).
  function automatic logic [din0_WIDTH-1:0] cneg0(input logic [din0_WIDTH-1:0] v,
                                                  input logic                  s);
    return s ? (~v + din0_WIDTH'(1)) : v;
  endfunction

  // Two's-complement negate when s is set (divisor-width operands).
  function automatic logic [din1_WIDTH-1:0] cneg1(input logic [din1_WIDTH-1:0] v,
                                                  input logic                  s);
    return s ? (~v + din1_WIDTH'(1)) : v;
  endfunction

  state_t                  state_r;
  logic [din0_WIDTH-1:0]   quo_r;    // dividend bits shift out, quotient bits shift in
  logic [din1_WIDTH-1:0]   part_r;   // partial remainder, always < divisor magnitude
  logic [din1_WIDTH-1:0]   dvs_r;    // divisor magnitude
  logic                    sgn0_r;
  logic                    sgn1_r;
  logic [CW-1:0]           cnt_r;
  logic                    pend_r;   // result registered, done due on next enabled edge
  logic                    done_r;
  logic [dout_WIDTH-1:0]   dout_r;
`ifdef COMPUTE_C_SDIV_REM_EN
  logic [din1_WIDTH-1:0]   rem_r;
`endif

  logic [din0_WIDTH-1:0]   din0_mag_s;
  logic [din1_WIDTH-1:0]   din1_mag_s;
  logic [din1_WIDTH:0]     shift_s;
  logic [din1_WIDTH:0]     diff_s;
  logic                    ge_s;
  logic                    unused_id_s;

  assign unused_id_s = ^ID;

  // Operand magnitudes and one restoring-division step.
  always_comb begin
    din0_mag_s = cneg0(din0, din0[din0_WIDTH-1]);
    din1_mag_s = cneg1(din1, din1[din1_WIDTH-1]);
    shift_s    = {part_r, quo_r[din0_WIDTH-1]};
    diff_s     = shift_s - {1'b0, dvs_r};
    if (shift_s >= {1'b0, dvs_r}) begin
      ge_s = 1'b1;
    end else begin
      ge_s = 1'b0;
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_r <= IDLE;
      quo_r   <= '0;
      part_r  <= '0;
      dvs_r   <= '0;
      sgn0_r  <= 1'b0;
      sgn1_r  <= 1'b0;
      cnt_r   <= '0;
      pend_r  <= 1'b0;
      done_r  <= 1'b0;
      dout_r  <= '0;
`ifdef COMPUTE_C_SDIV_REM_EN
      rem_r   <= '0;
`endif
    end else if (ce) begin
      done_r <= pend_r;
      pend_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            quo_r   <= din0_mag_s;
            dvs_r   <= din1_mag_s;
            part_r  <= '0;
            sgn0_r  <= din0[din0_WIDTH-1];
            sgn1_r  <= din1[din1_WIDTH-1];
            cnt_r   <= '0;
            state_r <= CALC;
          end
        end
        CALC: begin
          // With a zero divisor every step "fits", so part_r just shifts the
          // dividend through and ends holding its low din1_WIDTH bits.
          quo_r  <= {quo_r[din0_WIDTH-2:0], ge_s};
          part_r <= ge_s ? din1_WIDTH'(diff_s) : din1_WIDTH'(shift_s);
          cnt_r  <= cnt_r + CW'(1);
          if (cnt_r == CW'(din0_WIDTH - 1)) begin
            state_r <= SIGN;
          end
        end
        SIGN: begin
          if (dvs_r == '0) begin
            dout_r <= '1;
          end else begin
            dout_r <= dout_WIDTH'(cneg0(quo_r, sgn0_r ^ sgn1_r));
          end
`ifdef COMPUTE_C_SDIV_REM_EN
          rem_r <= cneg1(part_r, sgn0_r);
`endif
          pend_r  <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign done = done_r;
  assign dout = dout_r;
`ifdef COMPUTE_C_SDIV_REM_EN
  assign rem  = rem_r;
`endif

endmodule
